// File: rtl/register_file_stream_reader.sv
// Read-side sequencer for the 16x16 register file: fetches a burst of words
// by address and streams them out on a valid/ready interface with last/done.
module register_file_stream_reader #(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] start_addr_i,
    input  logic [AddrWidth:0]   len_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [AddrWidth-1:0] raddr_o,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [AddrWidth-1:0] out_addr_o,
    output logic                 out_last_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [AddrWidth:0]   RemZero = '0;
    localparam logic [AddrWidth:0]   RemOne  = {{AddrWidth{1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] PtrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

    state_e               r_state;
    logic [AddrWidth-1:0] r_rd_ptr;
    logic [AddrWidth:0]   r_rem;
    logic                 r_done;
    logic                 r_valid;
    logic                 r_last;
    logic [DataWidth-1:0] r_data;
    logic [AddrWidth-1:0] r_addr;

    logic w_fetch;
    logic w_handshake;

    // A new word may be fetched whenever the output slot is empty or is being
    // emptied by a handshake in this same cycle.
    assign w_fetch     = (r_state == RUN) && (r_rem != RemZero) && (!r_valid || out_ready_i);
    assign w_handshake = r_valid && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_rd_ptr <= '0;
            r_rem    <= '0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
        end else begin
            // NOTE: done is a pulse; this default is overridden only in the
            // cycles that complete a burst, so it self-clears the cycle after.
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        if (len_i != RemZero) begin
                            r_rd_ptr <= start_addr_i;
                            r_rem    <= len_i;
                            r_state  <= RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_rem   <= '0;
                    end else if (w_fetch) begin
                        r_data   <= rdata_i;
                        r_addr   <= r_rd_ptr;
                        r_valid  <= 1'b1;
                        r_last   <= (r_rem == RemOne);
                        r_rd_ptr <= r_rd_ptr + PtrOne;
                        r_rem    <= r_rem - RemOne;
                    end else if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        // rem is zero here, so this handshake drained the final word
                        if (r_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o      = (r_state == RUN);
    assign done_o      = r_done;
    assign raddr_o     = r_rd_ptr;
    assign out_valid_o = r_valid;
    assign out_last_o  = r_last;
    assign out_data_o  = r_data;
    assign out_addr_o  = r_addr;

endmodule

// File: tb/tb_register_file_stream_reader.sv
// Self-checking bench for register_file_stream_reader: a behavioural register
// file plus a per-burst expected-beat list derived from start address and length.
module tb_register_file_stream_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  start_addr_i = '0;
    logic [4:0]  len_i = '0;
    logic        abort_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  raddr_o;
    logic [15:0] rdata_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] out_data_o;
    logic [3:0]  out_addr_o;
    logic        out_last_o;

    logic [15:0] mem [16];
    int n_cmp = 0;
    int n_mis = 0;

    register_file_stream_reader #(.AddrWidth(4), .DataWidth(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .len_i        (len_i),
        .abort_i      (abort_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .raddr_o      (raddr_o),
        .rdata_i      (rdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_addr_o   (out_addr_o),
        .out_last_o   (out_last_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational read port of the register file.
    assign rdata_i = mem[raddr_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0,1,0,0...; 2: random ready.
    // inject: pulse a conflicting start while the burst is running.
    task automatic run_burst(input logic [3:0] sa, input int len, input int mode, input bit inject);
        logic [15:0] exp_data [$];
        logic [3:0]  exp_addr [$];
        int   idx;
        int   cyc;
        int   rctr;
        logic r;
        logic stalled;
        exp_data.delete();
        exp_addr.delete();
        for (int i = 0; i < len; i++) begin
            logic [3:0] a;
            a = 4'((int'(sa) + i) % 16);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
        end
        start_i      = 1'b1;
        start_addr_i = sa;
        len_i        = 5'(len);
        out_ready_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("valid_latency_1", 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        check("valid_latency_2", 32'(out_valid_o), 32'd1);
        idx     = 0;
        cyc     = 0;
        rctr    = 0;
        stalled = 1'b0;
        while (idx < len && cyc < 400) begin
            if (stalled) check("hold_valid", 32'(out_valid_o), 32'd1);
            if (out_valid_o) begin
                check("beat_data", 32'(out_data_o), 32'(exp_data[idx]));
                check("beat_addr", 32'(out_addr_o), 32'(exp_addr[idx]));
                check("beat_last", 32'(out_last_o), 32'(idx == len - 1));
            end
            check("no_done_mid", 32'(done_o), 32'd0);
            check("busy_mid", 32'(busy_o), 32'd1);
            case (mode)
                0:       r = 1'b1;
                1:       r = (rctr % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rctr++;
            out_ready_i = r;
            if (inject && idx == 2) begin
                start_i      = 1'b1;
                start_addr_i = sa + 4'd7;
                len_i        = 5'd3;
            end else begin
                start_i = 1'b0;
            end
            stalled = out_valid_o && !r;
            if (out_valid_o && r) idx++;
            @(negedge clk_i);
            cyc++;
        end
        start_i = 1'b0;
        check("burst_timeout", 32'(cyc < 400), 32'd1);
        if (mode == 0) check("throughput", 32'(cyc), 32'(len));
        check("done_pulse", 32'(done_o), 32'd1);
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("valid_after_done", 32'(out_valid_o), 32'd0);
        check("last_after_done", 32'(out_last_o), 32'd0);
        out_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        check("done_cleared", 32'(done_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_valid", 32'(out_valid_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_raddr", 32'(raddr_o), 32'd0);
        check("rst_data", 32'(out_data_o), 32'd0);
        check("rst_addr", 32'(out_addr_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Basic burst, stalled burst, wrap-around, full-range burst
        run_burst(4'd3, 4, 0, 1'b0);
        run_burst(4'd3, 4, 1, 1'b0);
        run_burst(4'd14, 4, 0, 1'b0);
        run_burst(4'd5, 16, 0, 1'b0);

        // Zero-length request: done pulse only
        start_i = 1'b1; start_addr_i = 4'd9; len_i = 5'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        check("len0_done", 32'(done_o), 32'd1);
        check("len0_busy", 32'(busy_o), 32'd0);
        check("len0_valid", 32'(out_valid_o), 32'd0);
        @(negedge clk_i);
        check("len0_done_clear", 32'(done_o), 32'd0);
        check("len0_valid2", 32'(out_valid_o), 32'd0);
        check("len0_busy2", 32'(busy_o), 32'd0);

        // Start pulsed mid-burst must be ignored
        run_burst(4'd1, 6, 0, 1'b1);

        // Abort after two handshakes with the third beat stalled
        start_i = 1'b1; start_addr_i = 4'd8; len_i = 5'd6; out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check("abort_beat0", 32'(out_data_o), 32'h1008);
        @(negedge clk_i);
        check("abort_beat1", 32'(out_data_o), 32'h1009);
        @(negedge clk_i);
        check("abort_beat2", 32'(out_data_o), 32'h100A);
        out_ready_i = 1'b0;
        @(negedge clk_i);
        check("abort_stall_valid", 32'(out_valid_o), 32'd1);
        check("abort_stall_data", 32'(out_data_o), 32'h100A);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_valid", 32'(out_valid_o), 32'd0);
        check("abort_last", 32'(out_last_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_no_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        check("abort_no_done2", 32'(done_o), 32'd0);
        run_burst(4'd0, 3, 2, 1'b0);

        // Random contents, addresses, lengths and backpressure
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            run_burst(4'($urandom_range(0, 15)), int'($urandom_range(1, 16)), 2, 1'b0);
        end

        // Reset mid-burst
        start_i = 1'b1; start_addr_i = 4'd2; len_i = 5'd10; out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_done", 32'(done_o), 32'd0);
        check("mrst_valid", 32'(out_valid_o), 32'd0);
        check("mrst_last", 32'(out_last_o), 32'd0);
        check("mrst_raddr", 32'(raddr_o), 32'd0);
        check("mrst_data", 32'(out_data_o), 32'd0);
        check("mrst_addr", 32'(out_addr_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_valid", 32'(out_valid_o), 32'd0);
            check("post_rst_busy", 32'(busy_o), 32'd0);
            check("post_rst_done", 32'(done_o), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/register_file_stream_reader.md
Name: register_file_stream_reader

Overview:
- Read-side sequencer for the latch-based 16x16 register file.
- Accepts a burst command: start address and length.
- Drives the register file read address and samples its combinational read data.
- Streams the words out on a valid/ready interface at up to one word per cycle, with a last flag and a done pulse.
- Sits between the register file read port and downstream consumers such as the decoder/accumulator datapath.

Parameters:
- AddrWidth, 4: register file address width; NumWords = 2**AddrWidth.
- DataWidth, 16: word width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  burst request, single-cycle qualifier.
- start_addr_i  in  AddrWidth  first word address of the burst.
- len_i  in  AddrWidth+1  number of words, 0..NumWords.
- abort_i  in  1  synchronous burst cancel.
- busy_o  out  1  high while a burst is in progress.
- done_o  out  1  one-cycle pulse on normal burst completion.
- raddr_o  out  AddrWidth  to register file raddr_a_i.
- rdata_i  in  DataWidth  from register file rdata_a_o.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  downstream accepts the word.
- out_data_o  out  DataWidth  output word.
- out_addr_o  out  AddrWidth  source address of out_data_o.
- out_last_o  out  1  marks the final word of the burst.

Behaviour:
- Reset (asynchronous assert, registered outputs cleared): state IDLE; busy_o, done_o, out_valid_o, out_last_o all 0; raddr_o, out_data_o, out_addr_o all 0; remaining count 0.
- States: IDLE and RUN.
- IDLE, start_i=1 and len_i>0: at the edge, rd_ptr<=start_addr_i, rem<=len_i, go to RUN; busy_o=1 from the next cycle.
- IDLE, start_i=1 and len_i=0: no state change to RUN; done_o=1 for exactly the next cycle; no beats are produced.
- start_i while busy_o=1 is ignored; no queuing.
- raddr_o = rd_ptr (registered), driven combinationally to the register file.
- RUN fetch condition: rem>0 and (out_valid_o=0 or out_ready_i=1).
- On fetch, at the edge:
  - out_data_o<=rdata_i, out_addr_o<=rd_ptr, out_valid_o<=1, out_last_o<=(rem==1).
  - rd_ptr<=rd_ptr+1, wrapping modulo NumWords.
  - rem<=rem-1.
- If out_valid_o=1 and out_ready_i=1 with no fetch, out_valid_o<=0 and out_last_o<=0.
- Data must be held stable while out_valid_o=1 and out_ready_i=0 (AXI-stream rule). The block never drops out_valid_o without a handshake, except on abort or reset.
- Throughput: one word per cycle with out_ready_i held high. First out_valid_o appears 2 cycles after the cycle in which start_i is accepted.
- Completion: the handshake of the word with out_last_o=1 moves the block to IDLE at that edge. done_o=1 in the following cycle; busy_o=0 from that cycle.
- A new start_i is accepted in the cycle done_o is high.
- len_i=NumWords reads every word exactly once, wrapping back to start_addr_i's predecessor; len_i>NumWords is not allowed.
- abort_i has priority over all other RUN activity. At the edge: state IDLE, out_valid_o<=0, out_last_o<=0, rem<=0. No done_o pulse. abort_i in IDLE has no effect, and abort_i has priority over a same-cycle start_i.
- Coherency with the register file:
  - rdata_i is sampled at the rising edge.
  - A word written with we_a_i=1 in cycle N is visible to a fetch at the edge closing cycle N+1 or later.
  - A write to the address equal to raddr_o in the fetch cycle itself is unsupported; the system must not issue it.
- Reset asserted mid-burst: all state cleared immediately, no done_o pulse; the burst is lost.

Test Plan:
- Preload words 0..15 with 0x1000+i; start_addr_i=3, len_i=4, out_ready_i=1 -> beats 0x1003..0x1006 on consecutive cycles, out_addr_o 3..6, out_last_o only on 0x1006, done_o one cycle after, busy_o then 0.
- Same burst with out_ready_i toggling 1,0,0,1,... -> no loss or duplication, data and addr stable during stalls, 4 handshakes total, done_o after the last.
- start_addr_i=14, len_i=4 -> out_addr_o sequence 14,15,0,1 with data 0x100E,0x100F,0x1000,0x1001; len_i=16 from addr 5 -> all 16 words once, last addr 4.
- len_i=0 -> done_o pulse next cycle, out_valid_o never high, busy_o stays 0; start_i pulsed mid-burst -> ignored, original burst completes unchanged.
- abort_i after 2 of 6 beats, out_ready_i=0 -> out_valid_o low next cycle, no done_o, busy_o 0; a new start_i is then accepted normally.
- rst_ni low mid-burst -> all outputs 0 immediately; after release, idle until start_i.
